zone_dimming_stats: RTL and testbench

Parametrised local-dimming statistics engine. It sits between the RGB-to-gray converter and the MiniLED driver, running in the LVDS pixel clock domain. It reduces a gray video stream to one brightness level per LED zone on a ZONES_X x ZONES_Y grid, with selectable max/average/mix/temporal-smoothed modes and ambient-light gain. Zone results are streamed out row by row during horizontal blanking, and a frame-done pulse follows the last zone.

---
 rtl/zone_dimming_pkg.sv | 39 +++
 rtl/zone_level_pipe.sv | 110 +++++++++++
 rtl/zone_dimming_stats.sv | 166 ++++++++++++++++
 tb/tb_zone_dimming_stats.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zone_dimming_pkg.sv
// Shared constants, FSM encoding and width helpers for the zone dimming statistics engine.
package zone_dimming_pkg;

  localparam logic [1:0] MODE_MAX = 2'b00;
  localparam logic [1:0] MODE_AVG = 2'b01;
  localparam logic [1:0] MODE_MIX = 2'b10;
  localparam logic [1:0] MODE_IIR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Zone column / zone row / flat zone index widths.
  function automatic int zx_w(input int zones_x);
    return cnt_w(zones_x);
  endfunction

  function automatic int zy_w(input int zones_y);
    return cnt_w(zones_y);
  endfunction

  function automatic int idx_w(input int zones_x, input int zones_y);
    return cnt_w(zones_x * zones_y);
  endfunction

  // Per-zone sum width: level width plus log2 of the pixel count of a zone.
  function automatic int sum_w(input int data_w, input int zone_w, input int zone_h);
    return data_w + $clog2(zone_w) + $clog2(zone_h);
  endfunction

endpackage

// File: rtl/zone_level_pipe.sv
// Three-stage level pipe: avg/mix reduction, temporal IIR with per-zone RAM, ambient gain.
module zone_level_pipe
  import zone_dimming_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SUM_W     = 19,
  parameter int AVG_SH    = 11,
  parameter int NZ        = 500,
  parameter int IDX_W     = 9,
  parameter int IIR_SHIFT = 2,
  parameter int GAIN_EN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [IDX_W-1:0]  issue_idx,
  input  logic              issue_last,
  input  logic [DATA_W-1:0] zone_max,
  input  logic [SUM_W-1:0]  zone_sum,
  input  logic [1:0]        mode,
  input  logic [7:0]        bright,
  input  logic              seed_clr,
  output logic              zone_valid,
  output logic [IDX_W-1:0]  zone_idx,
  output logic [DATA_W-1:0] zone_level,
  output logic              frame_done
);

  logic [DATA_W-1:0] avg_c, mix_c;
  logic [DATA_W:0]   mix_sum;

  logic              v1, last1;
  logic [IDX_W-1:0]  idx1;
  logic [1:0]        mode1;
  logic [7:0]        bright1;
  logic [DATA_W-1:0] max1, avg1, mix1;

  logic              v2, last2;
  logic [IDX_W-1:0]  idx2;
  logic [1:0]        mode2;
  logic [7:0]        bright2;
  logic [DATA_W-1:0] lvl2;

  logic              last3;
  logic [1:0]        mode3;
  logic              seed;

  logic [DATA_W-1:0]        ram [NZ];
  logic [DATA_W-1:0]        prev, clamped, iir_new, lvl_c, gain_lvl, out_c;
  logic signed [DATA_W:0]   diff, step;
  logic signed [DATA_W+1:0] step_x, nxt;
  logic [DATA_W+8:0]        prod;

  assign avg_c   = DATA_W'(zone_sum >> AVG_SH);
  assign mix_sum = {1'b0, zone_max} + {1'b0, avg_c} + {{DATA_W{1'b0}}, 1'b1};
  assign mix_c   = DATA_W'(mix_sum >> 1);

  // Temporal filter: step toward the new average by 1/2^IIR_SHIFT of the signed difference.
  assign prev   = ram[idx1];
  assign diff   = $signed({1'b0, avg1}) - $signed({1'b0, prev});
  assign step   = diff >>> IIR_SHIFT;
  assign step_x = {step[DATA_W], step};
  assign nxt    = $signed({2'b00, prev}) + step_x;

  always_comb begin
    if (nxt[DATA_W+1])  clamped = '0;
    else if (nxt[DATA_W]) clamped = '1;
    else                  clamped = nxt[DATA_W-1:0];
  end

  assign iir_new = seed ? clamped : avg1;

  always_comb begin
    lvl_c = max1;
    case (mode1)
      MODE_AVG: lvl_c = avg1;
      MODE_MIX: lvl_c = mix1;
      MODE_IIR: lvl_c = iir_new;
      default:  lvl_c = max1;
    endcase
  end

  assign prod     = (DATA_W+9)'(lvl2) * (DATA_W+9)'({1'b0, bright2} + 9'd1);
  assign gain_lvl = DATA_W'(prod >> 8);
  assign out_c    = (GAIN_EN != 0) ? gain_lvl : lvl2;

  always_ff @(posedge clk) begin
    if (v1 && mode1 == MODE_IIR) ram[idx1] <= iir_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; last1 <= 1'b0; idx1 <= '0; mode1 <= '0; bright1 <= '0;
      max1 <= '0; avg1 <= '0; mix1 <= '0;
      v2 <= 1'b0; last2 <= 1'b0; idx2 <= '0; mode2 <= '0; bright2 <= '0; lvl2 <= '0;
      zone_valid <= 1'b0; zone_idx <= '0; zone_level <= '0; last3 <= 1'b0; mode3 <= '0;
      frame_done <= 1'b0;
      seed <= 1'b0;
    end else begin
      v1 <= issue; last1 <= issue_last; idx1 <= issue_idx; mode1 <= mode; bright1 <= bright;
      max1 <= zone_max; avg1 <= avg_c; mix1 <= mix_c;
      v2 <= v1; last2 <= last1; idx2 <= idx1; mode2 <= mode1; bright2 <= bright1; lvl2 <= lvl_c;
      zone_valid <= v2; zone_idx <= idx2; zone_level <= out_c; last3 <= last2; mode3 <= mode2;
      frame_done <= zone_valid && last3;
      if (seed_clr) seed <= 1'b0;
      else if (zone_valid && last3 && mode3 == MODE_IIR) seed <= 1'b1;
    end
  end

endmodule

// File: rtl/zone_dimming_stats.sv
// Local-dimming statistics: per-zone max/sum accumulation, blanking-time flush into the level pipe.
module zone_dimming_stats
  import zone_dimming_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ZONE_W    = 64,
  parameter int ZONE_H    = 32,
  parameter int ZONES_X   = 20,
  parameter int ZONES_Y   = 25,
  parameter int IIR_SHIFT = 2,
  parameter int GAIN_EN   = 1
) (
  input  logic                                      I_clk,
  input  logic                                      I_rst_n,
  input  logic                                      I_vs,
  input  logic                                      I_de,
  input  logic [DATA_W-1:0]                         I_gray,
  input  logic [1:0]                                I_mode,
  input  logic [7:0]                                I_bright,
  output logic                                      O_zone_valid,
  output logic [idx_w(ZONES_X, ZONES_Y)-1:0]        O_zone_idx,
  output logic [DATA_W-1:0]                         O_zone_level,
  output logic                                      O_frame_done,
  output logic                                      O_overrun,
  output logic [1:0]                                O_dbg_state
);

  localparam int ZW_SH = $clog2(ZONE_W);
  localparam int ZH_SH = $clog2(ZONE_H);
  localparam int X_W   = cnt_w(ZONES_X * ZONE_W + 1);
  localparam int PC_W  = X_W - ZW_SH;
  localparam int ZX_W  = zx_w(ZONES_X);
  localparam int ZY_W  = zy_w(ZONES_Y);
  localparam int IDX_W = idx_w(ZONES_X, ZONES_Y);
  localparam int SUM_W = sum_w(DATA_W, ZONE_W, ZONE_H);
  localparam logic [PC_W-1:0] NCOL     = PC_W'(ZONES_X);
  localparam logic [ZX_W-1:0] LAST_COL = ZX_W'(ZONES_X - 1);
  localparam logic [ZY_W-1:0] LAST_ROW = ZY_W'(ZONES_Y - 1);

  state_t            state;
  logic              vs_d, de_d, vs_rise, de_rise, de_fall;
  logic [X_W-1:0]    x;
  logic [ZH_SH-1:0]  y;
  logic [PC_W-1:0]   pcol;
  logic [ZY_W-1:0]   zrow;
  logic [ZX_W-1:0]   fcol;
  logic [1:0]        mode_q;
  logic [7:0]        bright_q;
  logic              overrun;
  logic              first_px, accum_en, issue, issue_last, seed_clr;
  logic [IDX_W-1:0]  issue_idx;
  logic [DATA_W-1:0] max_r [ZONES_X];
  logic [SUM_W-1:0]  sum_r [ZONES_X];
  logic [DATA_W-1:0] flush_max;
  logic [SUM_W-1:0]  flush_sum;

  assign vs_rise  = I_vs && !vs_d;
  assign de_rise  = I_de && !de_d;
  assign de_fall  = !I_de && de_d;
  assign pcol     = x[X_W-1:ZW_SH];
  assign first_px = (x[ZW_SH-1:0] == '0) && (y == '0);
  // vsync wins over a coincident enable, so nothing accumulates on the frame-start cycle.
  assign accum_en = (state == ST_ACCUM) && I_de && !vs_rise && (pcol < NCOL);

  assign issue      = (state == ST_FLUSH) && !de_rise && !vs_rise;
  assign issue_idx  = IDX_W'(int'(zrow) * ZONES_X + int'(fcol));
  assign issue_last = (zrow == LAST_ROW) && (fcol == LAST_COL);
  assign flush_max  = max_r[fcol];
  assign flush_sum  = sum_r[fcol];
  // Only switching into or out of the temporal mode invalidates the stored history.
  assign seed_clr   = vs_rise && ((I_mode == MODE_IIR) != (mode_q == MODE_IIR));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_d <= 1'b0; de_d <= 1'b0; x <= '0; y <= '0; mode_q <= '0; bright_q <= '0;
    end else begin
      vs_d <= I_vs;
      de_d <= I_de;
      if (vs_rise) begin
        x <= '0; y <= '0; mode_q <= I_mode; bright_q <= I_bright;
      end else begin
        x <= I_de ? x + 1'b1 : '0;
        if (de_fall) y <= y + 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < ZONES_X; i++) begin
        max_r[i] <= '0;
        sum_r[i] <= '0;
      end
    end else if (accum_en) begin
      if (first_px) begin
        max_r[pcol] <= I_gray;
        sum_r[pcol] <= SUM_W'(I_gray);
      end else begin
        if (I_gray > max_r[pcol]) max_r[pcol] <= I_gray;
        sum_r[pcol] <= sum_r[pcol] + SUM_W'(I_gray);
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= ST_IDLE; zrow <= '0; fcol <= '0; overrun <= 1'b0;
    end else if (vs_rise) begin
      state <= ST_ACCUM; zrow <= '0; fcol <= '0;
    end else begin
      case (state)
        ST_ACCUM: if (de_fall && y == '1) begin
          state <= ST_FLUSH;
          fcol  <= '0;
        end
        ST_FLUSH: begin
          if (de_rise) begin
            // Blanking too short: the frame is abandoned until the next vsync.
            overrun <= 1'b1;
            state   <= ST_IDLE;
          end else if (fcol == LAST_COL) begin
            fcol <= '0;
            if (zrow == LAST_ROW) state <= ST_DONE;
            else begin
              state <= ST_ACCUM;
              zrow  <= zrow + 1'b1;
            end
          end else begin
            fcol <= fcol + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: ;
      endcase
    end
  end

  assign O_overrun   = overrun;
  assign O_dbg_state = state;

  zone_level_pipe #(
    .DATA_W   (DATA_W),
    .SUM_W    (SUM_W),
    .AVG_SH   (ZW_SH + ZH_SH),
    .NZ       (ZONES_X * ZONES_Y),
    .IDX_W    (IDX_W),
    .IIR_SHIFT(IIR_SHIFT),
    .GAIN_EN  (GAIN_EN)
  ) u_pipe (
    .clk       (I_clk),
    .rst_n     (I_rst_n),
    .issue     (issue),
    .issue_idx (issue_idx),
    .issue_last(issue_last),
    .zone_max  (flush_max),
    .zone_sum  (flush_sum),
    .mode      (mode_q),
    .bright    (bright_q),
    .seed_clr  (seed_clr),
    .zone_valid(O_zone_valid),
    .zone_idx  (O_zone_idx),
    .zone_level(O_zone_level),
    .frame_done(O_frame_done)
  );

endmodule

// File: tb/tb_zone_dimming_stats.sv
// Bench for zone_dimming_stats on a 2x2 grid of 4x2 zones (8x4 frame).
module tb_zone_dimming_stats;

  localparam int DATA_W = 8, ZONE_W = 4, ZONE_H = 2, ZONES_X = 2, ZONES_Y = 2;
  localparam int IIR_SHIFT = 2, GAIN_EN = 1;
  localparam int FW = ZONE_W * ZONES_X, FH = ZONE_H * ZONES_Y, NZ = ZONES_X * ZONES_Y;
  localparam int BLANK = 8;
  localparam int ENT_W = 10;

  logic       clk = 1'b0, rst_n = 1'b0, vs = 1'b0, de = 1'b0;
  logic [7:0] gray = '0, bright = '0;
  logic [1:0] mode = '0;
  logic       zone_valid, frame_done, overrun;
  logic [1:0] zone_idx, dbg_state;
  logic [7:0] zone_level;

  zone_dimming_stats #(
    .DATA_W(DATA_W), .ZONE_W(ZONE_W), .ZONE_H(ZONE_H), .ZONES_X(ZONES_X),
    .ZONES_Y(ZONES_Y), .IIR_SHIFT(IIR_SHIFT), .GAIN_EN(GAIN_EN)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_de(de), .I_gray(gray),
    .I_mode(mode), .I_bright(bright),
    .O_zone_valid(zone_valid), .O_zone_idx(zone_idx), .O_zone_level(zone_level),
    .O_frame_done(frame_done), .O_overrun(overrun), .O_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] ent;
  int n_cmp = 0, n_bad = 0;
  int n_valids = 0, n_done = 0;
  int fall_cyc = 0, last_zone_cyc = 0;
  logic [7:0] pix [FH][FW];

  // reference model state
  int iir_mem [NZ];
  int prev_mode = 0;
  bit seed_m = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (zone_valid) begin
        n_valids++;
        if (exp_q.size() == 0) begin
          check("unexpected_zone_valid", 1, 0);
        end else begin
          ent = exp_q.pop_front();
          check("zone_idx", int'(zone_idx), int'(ent[9:8]));
          check("zone_level", int'(zone_level), int'(ent[7:0]));
        end
        if (zone_idx % ZONES_X == 0) check("flush_latency", cyc - fall_cyc, 4);
        if (int'(zone_idx) == NZ - 1) last_zone_cyc = cyc;
      end
      if (frame_done) begin
        n_done++;
        check("frame_done_timing", cyc - last_zone_cyc, 1);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int floor_div(input int a, input int d);
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  function automatic void model_vs(input int m);
    if ((m == 3) != (prev_mode == 3)) seed_m = 1'b0;
    prev_mode = m;
  endfunction

  // Computes every zone level of the frame in pix; enqueues them when push is set.
  function automatic void model_frame(input int m, input int b, input bit push);
    int mx, sm, avg, mix, l, lv, idx;
    for (int zr = 0; zr < ZONES_Y; zr++) begin
      for (int zc = 0; zc < ZONES_X; zc++) begin
        mx = 0; sm = 0;
        for (int yy = 0; yy < ZONE_H; yy++)
          for (int xx = 0; xx < ZONE_W; xx++) begin
            int p;
            p = pix[zr*ZONE_H + yy][zc*ZONE_W + xx];
            if (p > mx) mx = p;
            sm += p;
          end
        idx = zr * ZONES_X + zc;
        avg = sm / (ZONE_W * ZONE_H);
        mix = (mx + avg + 1) / 2;
        case (m)
          0: l = mx;
          1: l = avg;
          2: l = mix;
          default: begin
            if (!seed_m) l = avg;
            else begin
              l = iir_mem[idx] + floor_div(avg - iir_mem[idx], 1 << IIR_SHIFT);
              if (l < 0) l = 0;
              if (l > 255) l = 255;
            end
            iir_mem[idx] = l;
          end
        endcase
        lv = (GAIN_EN != 0) ? (l * (b + 1)) / 256 : l;
        if (push) exp_q.push_back(ENT_W'((idx << 8) | lv));
      end
    end
    if (m == 3) seed_m = 1'b1;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_lines(input int blank);
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        de = 1'b1; gray = pix[y][x];
        tick(1);
      end
      de = 1'b0; gray = '0; fall_cyc = cyc;
      tick(blank);
    end
  endtask

  task automatic drive_frame(input int m, input int b, input int blank);
    mode = 2'(m); bright = 8'(b);
    vs = 1'b1; tick(2);
    vs = 1'b0; tick(3);
    drive_lines(blank);
    tick(10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_zone_valid"}, int'(zone_valid), 0);
    check({tag, "_zone_idx"}, int'(zone_idx), 0);
    check({tag, "_zone_level"}, int'(zone_level), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_state_idle"}, int'(dbg_state), 0);
  endtask

  task automatic random_pix();
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) pix[y][x] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int mode; int bright; int fill; int ramp0;
    int sp_en; int sx; int sy; int sv;
    int e0; int e1; int e2; int e3;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int d0, v0, m, b;

    vecs[0] = '{0, 255, 10,  0, 1, 5, 2, 200,  10,  10,  10, 200};
    vecs[1] = '{1, 255, 16,  1, 0, 0, 0, 0,     3,  16,  16,  16};
    vecs[2] = '{2, 255, 0,   0, 1, 0, 0, 255, 143,   0,   0,   0};
    vecs[3] = '{2, 127, 0,   0, 1, 0, 0, 255,  71,   0,   0,   0};
    vecs[4] = '{0, 0,   10,  0, 1, 5, 2, 200,   0,   0,   0,   0};
    vecs[5] = '{3, 255, 100, 0, 0, 0, 0, 0,   100, 100, 100, 100};
    vecs[6] = '{3, 255, 200, 0, 0, 0, 0, 0,   125, 125, 125, 125};
    vecs[7] = '{3, 255, 200, 0, 0, 0, 0, 0,   143, 143, 143, 143};
    vecs[8] = '{3, 255, 0,   0, 0, 0, 0, 0,   107, 107, 107, 107};

    // reset state
    rst_n = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(3);

    // table-driven frames
    for (int i = 0; i < 9; i++) begin
      for (int y = 0; y < FH; y++)
        for (int x = 0; x < FW; x++) begin
          pix[y][x] = 8'(vecs[i].fill);
          if (vecs[i].ramp0 != 0 && y < ZONE_H && x < ZONE_W) pix[y][x] = 8'(y * ZONE_W + x);
        end
      if (vecs[i].sp_en != 0) pix[vecs[i].sy][vecs[i].sx] = 8'(vecs[i].sv);
      model_vs(vecs[i].mode);
      model_frame(vecs[i].mode, vecs[i].bright, 1'b0);
      exp_q.push_back(ENT_W'((0 << 8) | vecs[i].e0));
      exp_q.push_back(ENT_W'((1 << 8) | vecs[i].e1));
      exp_q.push_back(ENT_W'((2 << 8) | vecs[i].e2));
      exp_q.push_back(ENT_W'((3 << 8) | vecs[i].e3));
      d0 = n_done;
      drive_frame(vecs[i].mode, vecs[i].bright, BLANK);
      check("vec_frame_done_count", n_done - d0, 1);
      check("vec_queue_drained", exp_q.size(), 0);
    end

    // overrun: one-cycle blanking aborts the frame before any zone is issued
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) pix[y][x] = 8'(50);
    model_vs(0);
    d0 = n_done; v0 = n_valids;
    drive_frame(0, 255, 1);
    check("overrun_set", int'(overrun), 1);
    check("overrun_no_done", n_done - d0, 0);
    check("overrun_no_zones", n_valids - v0, 0);
    check("overrun_state_idle", int'(dbg_state), 0);

    // following normal frame completes, overrun stays sticky
    random_pix();
    model_vs(0);
    model_frame(0, 255, 1'b1);
    d0 = n_done;
    drive_frame(0, 255, BLANK);
    check("post_overrun_done", n_done - d0, 1);
    check("overrun_sticky", int'(overrun), 1);
    check("post_overrun_drained", exp_q.size(), 0);

    // randomized frames against the model
    for (int f = 0; f < 14; f++) begin
      m = $urandom_range(0, 3);
      b = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
      random_pix();
      model_vs(m);
      model_frame(m, b, 1'b1);
      d0 = n_done;
      drive_frame(m, b, BLANK + $urandom_range(0, 4));
      check("rand_frame_done_count", n_done - d0, 1);
      check("rand_queue_drained", exp_q.size(), 0);
    end

    // reset mid-frame, then a frame without a vsync edge must produce nothing
    random_pix();
    mode = 2'd3; bright = 8'd255;
    vs = 1'b1; tick(2);
    vs = 1'b0; tick(3);
    for (int x = 0; x < 4; x++) begin
      de = 1'b1; gray = pix[0][x];
      tick(1);
    end
    rst_n = 1'b0; de = 1'b0; gray = '0;
    exp_q.delete();
    prev_mode = 0; seed_m = 1'b0;
    tick(2);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    tick(2);
    v0 = n_valids; d0 = n_done;
    drive_lines(BLANK);
    tick(10);
    check("no_vs_no_zones", n_valids - v0, 0);
    check("no_vs_no_done", n_done - d0, 0);
    check("no_vs_state_idle", int'(dbg_state), 0);

    // first synced frame after reset in temporal mode starts from a fresh seed
    random_pix();
    model_vs(3);
    model_frame(3, 255, 1'b1);
    d0 = n_done;
    drive_frame(3, 255, BLANK);
    check("after_reset_done", n_done - d0, 1);
    check("after_reset_drained", exp_q.size(), 0);
    check("after_reset_overrun_clear", int'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
